// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: per-channel debounce state
// encoding and the channel index assignment used on the raw/level vectors.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } chan_state_e;

  localparam int unsigned START  = 0;
  localparam int unsigned STOP   = 1;
  localparam int unsigned RESET  = 2;
  localparam int unsigned NUM_CH = 3;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One push-button channel: 2-flop synchronizer, polarity normalisation,
// stable-sample debounce FSM and a registered one-cycle press pulse.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_press,
  output logic o_level
);

  localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic                 RELEASED = BTN_ACTIVE_LOW;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_press;
  chan_state_e      r_state;
  chan_state_e      w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_pressed;
  logic             w_press_evt;

  assign w_pressed = BTN_ACTIVE_LOW ? ~r_sync2 : r_sync2;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Synchronizers idle at the released level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= RELEASED;
      r_sync2 <= RELEASED;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      r_press <= w_press_evt;
    end
  end

  // The counter tops out at CNT_LAST-1 in any state, so it cannot wrap.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_pressed) begin
          w_next_state = PRESS_WAIT;
          w_cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_pressed) begin
          w_next_state = IDLE;
          w_cnt_next   = '0;
        end else if (w_cnt_inc == CNT_LAST) begin
          w_next_state = PRESSED;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = w_cnt_inc;
        end
      end
      PRESSED: begin
        if (!w_pressed) begin
          w_next_state = RELEASE_WAIT;
          w_cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_pressed) begin
          w_next_state = PRESSED;
          w_cnt_next   = '0;
        end else if (w_cnt_inc == CNT_LAST) begin
          w_next_state = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = w_cnt_inc;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    w_press_evt = (r_state == PRESS_WAIT) && (w_next_state == PRESSED);
    o_level     = (r_state == PRESSED) || (r_state == RELEASE_WAIT);
  end

  assign o_press = r_press;

endmodule

// File: rtl/button_conditioner.sv
// Debounces the start/stop/clear buttons of the stopwatch and turns accepted
// presses into prioritised, registered one-cycle command pulses.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk_50mhz,
  input  logic       reset_n,
  input  logic       start_btn_raw,
  input  logic       stop_btn_raw,
  input  logic       reset_btn_raw,
  output logic       start,
  output logic       stop,
  output logic       reset,
  output logic [2:0] btn_level
);

  logic [NUM_CH-1:0] w_raw;
  logic [NUM_CH-1:0] w_press;
  logic [NUM_CH-1:0] w_level;
  logic              r_start;
  logic              r_stop;
  logic              r_reset;
  logic [NUM_CH-1:0] r_level;

  assign w_raw[START] = start_btn_raw;
  assign w_raw[STOP]  = stop_btn_raw;
  assign w_raw[RESET] = reset_btn_raw;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_ch (
      .clk     (clk_50mhz),
      .rst_n   (reset_n),
      .i_raw   (w_raw[g]),
      .o_press (w_press[g]),
      .o_level (w_level[g])
    );
  end

  // Clear beats stop beats start; a losing pulse is simply dropped.
  always_ff @(posedge clk_50mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_reset <= 1'b0;
      r_level <= '0;
    end else begin
      r_reset <= w_press[RESET];
      r_stop  <= w_press[STOP] & ~w_press[RESET];
      r_start <= w_press[START] & ~w_press[STOP] & ~w_press[RESET];
      r_level <= w_level;
    end
  end

  assign start     = r_start;
  assign stop      = r_stop;
  assign reset     = r_reset;
  assign btn_level = r_level;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a run-length debounce model predicts every
// output each cycle; directed scenarios pin absolute timing and priority.
module tb_button_conditioner;

  localparam int DEB = 8;
  localparam int LAT = 3;

  logic       clk_50mhz     = 1'b0;
  logic       reset_n       = 1'b1;
  logic       start_btn_raw = 1'b1;
  logic       stop_btn_raw  = 1'b1;
  logic       reset_btn_raw = 1'b1;
  logic       start;
  logic       stop;
  logic       reset;
  logic [2:0] btn_level;

  int n_checks = 0;
  int n_pass   = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .BTN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk_50mhz     (clk_50mhz),
    .reset_n       (reset_n),
    .start_btn_raw (start_btn_raw),
    .stop_btn_raw  (stop_btn_raw),
    .reset_btn_raw (reset_btn_raw),
    .start         (start),
    .stop          (stop),
    .reset         (reset),
    .btn_level     (btn_level)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a level flips after DEB consecutive samples disagreeing with it;
  // a flip to pressed is a press. Results appear LAT edges after the sample.
  logic [2:0] m_lvl = '0;
  int         m_run [3];
  logic [5:0] h0 = '0, h1 = '0, h2 = '0, exp_o = '0;

  initial begin
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    forever begin
      @(posedge clk_50mhz or negedge reset_n);
      if (!reset_n) begin
        m_lvl = '0;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
        h0 = '0; h1 = '0; h2 = '0; exp_o = '0;
      end else begin
        logic [2:0] prs;
        logic [2:0] p;
        prs = ~{reset_btn_raw, stop_btn_raw, start_btn_raw};
        p   = '0;
        for (int i = 0; i < 3; i++) begin
          if (prs[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
              m_lvl[i] = prs[i];
              m_run[i] = 0;
              p[i]     = prs[i];
            end
          end else begin
            m_run[i] = 0;
          end
        end
        exp_o = h2;
        h2 = h1;
        h1 = h0;
        h0 = {m_lvl, p[2], p[1] & ~p[2], p[0] & ~p[1] & ~p[2]};
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_50mhz);
      check("model_cycle", {2'b00, btn_level, reset, stop, start}, {2'b00, exp_o});
    end
  end

  int         obs_start, obs_stop, obs_reset;
  logic [2:0] obs_or, obs_and;

  task automatic clr_obs();
    obs_start = 0; obs_stop = 0; obs_reset = 0;
    obs_or = '0; obs_and = '1;
  endtask

  task automatic obs_cycle();
    @(negedge clk_50mhz);
    obs_start += int'(start);
    obs_stop  += int'(stop);
    obs_reset += int'(reset);
    obs_or    |= btn_level;
    obs_and   &= btn_level;
    #1;
  endtask

  logic [2:0] rv;
  int         hold [3];

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) obs_cycle();
    check("reset_state", {btn_level, reset, stop, start}, 6'd0);
    reset_n = 1'b1;
    repeat (4) obs_cycle();

    // Clean 20-cycle start press: pulse exactly at edge 10, level until 10 after release.
    start_btn_raw = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk_50mhz); @(negedge clk_50mhz);
      check("press_start_pulse", start, (j == 10));
    end
    #1 start_btn_raw = 1'b1;
    for (int j = 0; j < 13; j++) begin
      @(posedge clk_50mhz); @(negedge clk_50mhz);
      check("press_level_release", btn_level[0], (j < 10));
    end
    #1;
    repeat (4) obs_cycle();

    // Stop bouncing every 3 cycles never settles.
    clr_obs();
    for (int k = 0; k < 30; k++) begin
      stop_btn_raw = ((k / 3) % 2 == 0) ? 1'b0 : 1'b1;
      obs_cycle();
    end
    stop_btn_raw = 1'b1;
    repeat (12) obs_cycle();
    check("bounce_stop_pulses", obs_stop, 0);
    check("bounce_level", obs_or, 3'b000);

    // Start and stop together: stop wins.
    clr_obs();
    start_btn_raw = 1'b0; stop_btn_raw = 1'b0;
    repeat (20) obs_cycle();
    start_btn_raw = 1'b1; stop_btn_raw = 1'b1;
    repeat (14) obs_cycle();
    check("pair_stop_pulses", obs_stop, 1);
    check("pair_start_pulses", obs_start, 0);
    check("pair_levels", obs_or, 3'b011);

    // All three together: only clear pulses.
    clr_obs();
    start_btn_raw = 1'b0; stop_btn_raw = 1'b0; reset_btn_raw = 1'b0;
    repeat (20) obs_cycle();
    start_btn_raw = 1'b1; stop_btn_raw = 1'b1; reset_btn_raw = 1'b1;
    repeat (14) obs_cycle();
    check("all_reset_pulses", obs_reset, 1);
    check("all_stop_pulses", obs_stop, 0);
    check("all_start_pulses", obs_start, 0);

    // reset_n mid-debounce: partial count discarded, fresh debounce after release.
    start_btn_raw = 1'b0;
    repeat (5) obs_cycle();
    reset_n = 1'b0;
    #1 check("midpress_reset_outputs", {btn_level, reset, stop, start}, 6'd0);
    @(negedge clk_50mhz);
    #1 reset_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk_50mhz); @(negedge clk_50mhz);
      check("after_reset_start_pulse", start, (j == 10));
    end
    #1 start_btn_raw = 1'b1;
    repeat (12) obs_cycle();

    // Release bounce is swallowed.
    start_btn_raw = 1'b0;
    repeat (12) obs_cycle();
    clr_obs();
    start_btn_raw = 1'b1;
    repeat (3) obs_cycle();
    start_btn_raw = 1'b0;
    repeat (15) obs_cycle();
    check("relbounce_no_pulse", obs_start, 0);
    check("relbounce_level_held", obs_and[0], 1'b1);
    reset_n = 1'b0;
    #1 check("async_clear_level", btn_level, 3'b000);
    start_btn_raw = 1'b1;
    @(negedge clk_50mhz);
    #1 reset_n = 1'b1;
    repeat (4) obs_cycle();

    // Randomised mix of bouncy and held presses with occasional resets.
    rv = 3'b111;
    for (int i = 0; i < 3; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          rv[i]   = 1'($urandom_range(0, 1));
          hold[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4))
                                                : int'($urandom_range(8, 25));
        end else begin
          hold[i]--;
        end
      end
      {reset_btn_raw, stop_btn_raw, start_btn_raw} = rv;
      reset_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      @(negedge clk_50mhz);
      #1;
    end
    reset_n = 1'b1;
    {reset_btn_raw, stop_btn_raw, start_btn_raw} = 3'b111;
    repeat (LAT + DEB + 4) obs_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable samples required to accept a level change (20 ms at 50 MHz); legal range 2 to 2^24.
REQ-002 SHALL have parameter BTN_ACTIVE_LOW, default 1, meaning raw buttons read 0 when pressed.
REQ-003 SHALL have port clk_50mhz, input, 1 bit, sole clock.
REQ-004 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port start_btn_raw, input, 1 bit, asynchronous raw start push-button.
REQ-006 SHALL have port stop_btn_raw, input, 1 bit, asynchronous raw stop push-button.
REQ-007 SHALL have port reset_btn_raw, input, 1 bit, asynchronous raw stopwatch-clear push-button.
REQ-008 SHALL have port start, output, 1 bit, one-cycle press pulse for the stopwatch start input.
REQ-009 SHALL have port stop, output, 1 bit, one-cycle press pulse for the stopwatch stop input.
REQ-010 SHALL have port reset, output, 1 bit, one-cycle press pulse for the stopwatch reset input; this is a command, not this block's reset.
REQ-011 SHALL have port btn_level, output, 3 bits, debounced held levels {reset, stop, start}, 1 = pressed.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer, then polarity-normalize so 1 = pressed.
REQ-013 Each channel SHALL run FSM IDLE -> PRESS_WAIT -> PRESSED -> RELEASE_WAIT -> IDLE.
REQ-014 IDLE: sampled pressed -> PRESS_WAIT, counter cleared to 0.
REQ-015 PRESS_WAIT: pressed increments counter; on counter == DEBOUNCE_CYCLES-1 -> PRESSED; released -> IDLE with counter cleared (bounce rejects).
REQ-016 PRESSED: sampled released -> RELEASE_WAIT, counter cleared.
REQ-017 RELEASE_WAIT: released increments to DEBOUNCE_CYCLES-1 -> IDLE; pressed -> PRESSED (release bounce rejected, no new pulse).
REQ-018 Raw press pulse SHALL assert for exactly one cycle on the PRESS_WAIT -> PRESSED transition cycle+1, i.e. 2+DEBOUNCE_CYCLES cycles after the first clk edge sampling a clean press.
REQ-019 btn_level bit SHALL be 1 in PRESSED and RELEASE_WAIT, else 0.
REQ-020 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); counter SHALL never wrap.
REQ-021 Holding a button SHALL produce one pulse only; next pulse requires return to IDLE.
REQ-022 Priority, same cycle: reset pulse suppresses start and stop; stop suppresses start; suppressed pulses are dropped, not deferred.
REQ-023 Outputs start, stop, reset SHALL be registered (no combinational path from raw inputs).

Reset
REQ-024 reset_n low SHALL asynchronously force all FSMs to IDLE, counters to 0, synchronizer flops to the released level, and start, stop, reset, btn_level to 0.
REQ-025 A button held through reset_n deassertion SHALL be debounced afresh and produce one pulse after 2+DEBOUNCE_CYCLES cycles.
REQ-026 reset_n asserted mid-PRESS_WAIT SHALL discard the partial count; no pulse is emitted.

Structure
REQ-027 Shared package SHALL hold the channel state encoding (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT) and channel index constants START=0, STOP=1, RESET=2.
REQ-028 One sub-module debounce_channel (synchronizer, FSM, counter, pulse) SHALL be instantiated three times; priority logic and output registers stay in button_conditioner.

Verification (DEBOUNCE_CYCLES=8, BTN_ACTIVE_LOW=1)
REQ-029 start_btn_raw low held 20 cycles -> start high exactly one cycle, 10 cycles after first sampling edge; btn_level[0]=1 until 2+8 cycles after release.
REQ-030 stop_btn_raw toggling low/high every 3 cycles for 30 cycles, then high -> stop never asserts, btn_level stays 000.
REQ-031 start_btn_raw and stop_btn_raw pressed on same edge, held 20 cycles -> stop pulses once, start stays 0 throughout.
REQ-032 All three pressed together -> only reset pulses; start and stop stay 0.
REQ-033 reset_n pulsed low at cycle 5 of a 20-cycle start press -> outputs 0 immediately; start pulses once 10 cycles after reset_n rises.
REQ-034 Release bounce: after accepted press, raw high 3 cycles then low again -> no second start pulse; btn_level[0] stays 1.
